// File: rtl/instr_mem_dbg.sv
// Instruction memory for the fetch stage: registered fetch port with stall/flush/fault,
// plus a halted-core debug port (IDLE/RD/RESP) returning {ok, addr, data} packets.
module instr_mem_dbg #(
   parameter int DEPTH = 256,
   parameter int XLEN = 32,
   parameter int DBG_AW = 9,
   parameter logic [XLEN-1:0] NOP = 32'h00000013
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fetch_en,
   input  logic                     flush,
   input  logic [XLEN-1:0]          pc,
   output logic [XLEN-1:0]          instr,
   output logic                     instr_valid,
   output logic                     instr_fault,
   input  logic                     core_halted,
   input  logic                     dbg_req_valid,
   output logic                     dbg_req_ready,
   input  logic                     dbg_we,
   input  logic [DBG_AW-1:0]        dbg_addr,
   input  logic [XLEN-1:0]          dbg_wdata,
   output logic                     dbg_rsp_valid,
   input  logic                     dbg_rsp_ready,
   output logic [DBG_AW+XLEN:0]     dbg_rsp_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [XLEN-3:0] DEPTH_PC = (XLEN-2)'(DEPTH);
   localparam logic [DBG_AW:0] DEPTH_DBG = (DBG_AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

   state_t state, state_nxt;

   logic [XLEN-1:0]   mem [DEPTH] = '{default: NOP};
   logic [DBG_AW-1:0] rd_addr;
   logic              pc_bad;
   logic              addr_ok;
   logic              rd_ok;
   logic              accept;
   logic              wr_en;
   logic [AW-1:0]     pc_idx;
   logic [AW-1:0]     dbg_idx;
   logic [AW-1:0]     rd_idx;

   // Range checks use the full address width so high bits never alias into the array.
   always_comb begin
      pc_bad  = (pc[1:0] != 2'b00) || (pc[XLEN-1:2] >= DEPTH_PC);
      addr_ok = {1'b0, dbg_addr} < DEPTH_DBG;
      rd_ok   = {1'b0, rd_addr} < DEPTH_DBG;
      pc_idx  = pc[AW+1:2];
      dbg_idx = dbg_addr[AW-1:0];
      rd_idx  = rd_addr[AW-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr       <= NOP;
         instr_valid <= 1'b0;
         instr_fault <= 1'b0;
      end else if (flush) begin
         instr       <= NOP;
         instr_valid <= 1'b0;
         instr_fault <= 1'b0;
      end else if (fetch_en) begin
         if (pc_bad) begin
            instr       <= NOP;
            instr_valid <= 1'b0;
            instr_fault <= 1'b1;
         end else begin
            instr       <= mem[pc_idx];
            instr_valid <= 1'b1;
            instr_fault <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[dbg_idx] <= dbg_wdata;
      end
   end

   always_comb begin
      state_nxt     = state;
      dbg_req_ready = (state == IDLE) && core_halted && !reset;
      accept        = dbg_req_valid && dbg_req_ready;
      wr_en         = accept && dbg_we && addr_ok;
      case (state)
         IDLE:    if (accept) state_nxt = dbg_we ? RESP : RD;
         RD:      state_nxt = RESP;
         RESP:    if (dbg_rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         dbg_rsp_valid <= 1'b0;
         dbg_rsp_data  <= '0;
         rd_addr       <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (dbg_we) begin
                     dbg_rsp_valid <= 1'b1;
                     dbg_rsp_data  <= {addr_ok, dbg_addr, addr_ok ? dbg_wdata : {XLEN{1'b0}}};
                  end else begin
                     rd_addr <= dbg_addr;
                  end
               end
            end
            RD: begin
               dbg_rsp_valid <= 1'b1;
               dbg_rsp_data  <= {rd_ok, rd_addr, rd_ok ? mem[rd_idx] : {XLEN{1'b0}}};
            end
            RESP: begin
               if (dbg_rsp_ready) dbg_rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
